// File: rtl/risc_ctrl_seq.sv
// Instruction-sequencing controller: eight-phase fetch/execute flow with memory
// wait states, illegal-opcode detection, a sticky halt and a retired-instruction count.
module risc_ctrl_seq #(
  parameter int OPCODE_WIDTH = 3,
  parameter int MEM_WAIT     = 0,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    is_zero,
  input  logic                    mem_ready,
  input  logic                    resume,
  output logic                    sel,
  output logic                    rd,
  output logic                    ld_ir,
  output logic                    halt,
  output logic                    inc_pc,
  output logic                    ld_ac,
  output logic                    ld_pc,
  output logic                    wr,
  output logic                    data_e,
  output logic                    illegal,
  output logic [CNT_WIDTH-1:0]    retired
);

  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_t;

  localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

  state_t               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic       ill;
  logic [2:0] op_lo;
  logic       is_hlt, is_skz, is_jmp, is_sto, aluop;
  logic       w_met;
  logic       enter_hold;

  // Any set bit above the three architectural opcode bits makes the code illegal.
  generate
    if (OPCODE_WIDTH > 3) begin : g_wide_op
      assign ill = |opcode[OPCODE_WIDTH-1:3];
    end else begin : g_narrow_op
      assign ill = 1'b0;
    end
  endgenerate

  assign op_lo  = opcode[2:0];
  assign is_hlt = !ill && (op_lo == 3'd0);
  assign is_skz = !ill && (op_lo == 3'd1);
  assign is_sto = !ill && (op_lo == 3'd6);
  assign is_jmp = !ill && (op_lo == 3'd7);
  assign aluop  = !ill && ((op_lo == 3'd2) || (op_lo == 3'd3) ||
                           (op_lo == 3'd4) || (op_lo == 3'd5));
  assign w_met  = (wcnt_q == WAIT_MAX) && mem_ready;

  // Next-state, wait-counter and retire-count logic.
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      S_INST_ADDR:  state_d = S_INST_FETCH;
      S_INST_FETCH: begin
        if (w_met) begin
          state_d = S_INST_LOAD;
        end else begin
          state_d = S_INST_FETCH;
        end
      end
      S_INST_LOAD:  state_d = S_IDLE;
      S_IDLE:       state_d = S_OP_ADDR;
      S_OP_ADDR: begin
        if (is_hlt) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_OP_FETCH;
        end
      end
      S_OP_FETCH: begin
        if (!aluop || w_met) begin
          state_d = S_ALU_OP;
        end else begin
          state_d = S_OP_FETCH;
        end
      end
      S_ALU_OP:     state_d = S_STORE;
      S_STORE: begin
        state_d   = S_INST_ADDR;
        retired_d = retired_q + CNT_WIDTH'(1);
      end
      S_HALTED: begin
        if (resume) begin
          state_d = S_INST_ADDR;
        end else begin
          state_d = S_HALTED;
        end
      end
      default:      state_d = S_INST_ADDR;
    endcase

    // The counter restarts on entry to a read hold and otherwise saturates.
    enter_hold = (state_d != state_q) &&
                 ((state_d == S_INST_FETCH) || ((state_d == S_OP_FETCH) && aluop));
    if (enter_hold) begin
      wcnt_d = 4'd0;
    end else if (wcnt_q != WAIT_MAX) begin
      wcnt_d = wcnt_q + 4'd1;
    end else begin
      wcnt_d = wcnt_q;
    end
  end

  // Control strobes decoded from the current phase; reset forces the PC address path only.
  always_comb begin
    sel     = 1'b0;
    rd      = 1'b0;
    ld_ir   = 1'b0;
    halt    = 1'b0;
    inc_pc  = 1'b0;
    ld_ac   = 1'b0;
    ld_pc   = 1'b0;
    wr      = 1'b0;
    data_e  = 1'b0;
    illegal = 1'b0;
    if (!rst_n) begin
      sel = 1'b1;
    end else begin
      case (state_q)
        S_INST_ADDR:  sel = 1'b1;
        S_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        S_INST_LOAD, S_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        S_OP_ADDR: begin
          inc_pc  = 1'b1;
          illegal = ill;
        end
        S_OP_FETCH:   rd = aluop;
        S_ALU_OP: begin
          rd     = aluop;
          inc_pc = is_skz && is_zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        S_STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        S_HALTED: begin
          halt = 1'b1;
          sel  = 1'b1;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  // Phase, wait-counter and retire-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INST_ADDR;
      wcnt_q    <= 4'd0;
      retired_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_risc_ctrl_seq.sv
// Directed scoreboard bench: a zero-wait, 4-bit-opcode, 4-bit-counter instance (A)
// and a MEM_WAIT=2 instance (B), each checked every cycle against queued expectations.
module tb_risc_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       is_zero, mem_ready, resume;

  logic a_sel, a_rd, a_ld_ir, a_halt, a_inc_pc, a_ld_ac, a_ld_pc, a_wr, a_data_e, a_illegal;
  logic b_sel, b_rd, b_ld_ir, b_halt, b_inc_pc, b_ld_ac, b_ld_pc, b_wr, b_data_e, b_illegal;
  logic [3:0]  a_retired;
  logic [15:0] b_retired;

  always #5 clk = ~clk;

  risc_ctrl_seq #(.OPCODE_WIDTH(4), .MEM_WAIT(0), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .is_zero(is_zero),
    .mem_ready(mem_ready), .resume(resume),
    .sel(a_sel), .rd(a_rd), .ld_ir(a_ld_ir), .halt(a_halt), .inc_pc(a_inc_pc),
    .ld_ac(a_ld_ac), .ld_pc(a_ld_pc), .wr(a_wr), .data_e(a_data_e),
    .illegal(a_illegal), .retired(a_retired)
  );

  risc_ctrl_seq #(.OPCODE_WIDTH(3), .MEM_WAIT(2), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode[2:0]), .is_zero(is_zero),
    .mem_ready(mem_ready), .resume(resume),
    .sel(b_sel), .rd(b_rd), .ld_ir(b_ld_ir), .halt(b_halt), .inc_pc(b_inc_pc),
    .ld_ac(b_ld_ac), .ld_pc(b_ld_pc), .wr(b_wr), .data_e(b_data_e),
    .illegal(b_illegal), .retired(b_retired)
  );

  // Bit order: sel rd ld_ir halt inc_pc ld_ac ld_pc wr data_e illegal
  logic [9:0] a_vec, b_vec;
  assign a_vec = {a_sel, a_rd, a_ld_ir, a_halt, a_inc_pc, a_ld_ac, a_ld_pc, a_wr, a_data_e, a_illegal};
  assign b_vec = {b_sel, b_rd, b_ld_ir, b_halt, b_inc_pc, b_ld_ac, b_ld_pc, b_wr, b_data_e, b_illegal};

  typedef struct packed {
    logic [9:0]  o;
    logic [15:0] r;
    int          id;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   step_id = 0;
  logic [3:0]  ret_a = 4'd0;
  logic [15:0] ret_b = 16'd0;

  localparam logic [9:0] V_RST  = 10'b1000000000;
  localparam logic [9:0] V_HALT = 10'b1001000000;

  task automatic push(input bit to_b, input logic [9:0] o, input logic [15:0] r);
    exp_t e;
    e.o  = o;
    e.r  = r;
    e.id = step_id;
    step_id++;
    if (to_b) qb.push_back(e);
    else      qa.push_back(e);
  endtask

  // Expected per-cycle trace of one instruction; ifl/ofl are fetch-hold lengths.
  task automatic push_instr(input bit to_b, input logic [3:0] op, input logic z,
                            input int ifl, input int ofl);
    logic [15:0] r;
    logic alu, ill, skz, jmp, sto, hlt;
    int n;
    r   = to_b ? ret_b : {12'd0, ret_a};
    alu = (op >= 4'd2) && (op <= 4'd5);
    ill = (op > 4'd7);
    skz = (op == 4'd1);
    jmp = (op == 4'd7);
    sto = (op == 4'd6);
    hlt = (op == 4'd0);
    push(to_b, 10'b1000000000, r);
    for (int i = 0; i < ifl; i++) push(to_b, 10'b1100000000, r);
    push(to_b, 10'b1110000000, r);
    push(to_b, 10'b1110000000, r);
    push(to_b, {9'b000010000, ill}, r);
    if (!hlt) begin
      n = alu ? ofl : 1;
      for (int i = 0; i < n; i++) push(to_b, {1'b0, alu, 8'b00000000}, r);
      push(to_b, {1'b0, alu, 2'b00, skz & z, 1'b0, jmp, 1'b0, sto, 1'b0}, r);
      push(to_b, {1'b0, alu, 3'b000, alu, jmp, sto, sto, 1'b0}, r);
      if (to_b) ret_b = ret_b + 16'd1;
      else      ret_a = ret_a + 4'd1;
    end
  endtask

  // Advance up to n cycles, comparing each instance that has a pending expectation.
  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n && (qa.size() > 0 || qb.size() > 0); i++) begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        checks++;
        assert (a_vec === e.o) else begin
          errors++;
          $error("FAIL A.out#%0d: got %b expected %b", e.id, a_vec, e.o);
        end
        checks++;
        assert ({12'd0, a_retired} === e.r) else begin
          errors++;
          $error("FAIL A.retired#%0d: got %0d expected %0d", e.id, a_retired, e.r);
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        checks++;
        assert (b_vec === e.o) else begin
          errors++;
          $error("FAIL B.out#%0d: got %b expected %b", e.id, b_vec, e.o);
        end
        checks++;
        assert (b_retired === e.r) else begin
          errors++;
          $error("FAIL B.retired#%0d: got %0d expected %0d", e.id, b_retired, e.r);
        end
      end
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 4'd2;
    is_zero   = 1'b0;
    mem_ready = 1'b1;
    resume    = 1'b0;

    // Reset state on both instances
    push(1'b0, V_RST, 16'd0);
    push(1'b0, V_RST, 16'd0);
    push(1'b1, V_RST, 16'd0);
    push(1'b1, V_RST, 16'd0);
    drain(50);
    release_reset();

    // Baseline ADD, SKZ taken/not taken, JMP, STO, remaining ALU ops
    push_instr(1'b0, 4'd2, 1'b0, 1, 1); drain(50);
    is_zero = 1'b1;
    opcode = 4'd1; push_instr(1'b0, 4'd1, 1'b1, 1, 1); drain(50);
    is_zero = 1'b0;
    push_instr(1'b0, 4'd1, 1'b0, 1, 1); drain(50);
    opcode = 4'd7; push_instr(1'b0, 4'd7, 1'b0, 1, 1); drain(50);
    opcode = 4'd6; push_instr(1'b0, 4'd6, 1'b0, 1, 1); drain(50);
    is_zero = 1'b1;
    opcode = 4'd3; push_instr(1'b0, 4'd3, 1'b1, 1, 1); drain(50);
    opcode = 4'd4; push_instr(1'b0, 4'd4, 1'b1, 1, 1); drain(50);
    opcode = 4'd5; push_instr(1'b0, 4'd5, 1'b1, 1, 1); drain(50);
    is_zero = 1'b0;

    // HLT: sticky halt, then a one-cycle resume pulse
    opcode = 4'd0; push_instr(1'b0, 4'd0, 1'b0, 1, 1);
    for (int i = 0; i < 11; i++) push(1'b0, V_HALT, {12'd0, ret_a});
    drain(50);
    resume = 1'b1;
    opcode = 4'd2; push_instr(1'b0, 4'd2, 1'b0, 1, 1);
    drain(1);
    resume = 1'b0;
    drain(50);

    // Illegal opcodes, then enough ADDs to wrap the 4-bit retire count
    opcode = 4'd9;  push_instr(1'b0, 4'd9,  1'b1, 1, 1); drain(50);
    opcode = 4'd15; push_instr(1'b0, 4'd15, 1'b0, 1, 1); drain(50);
    opcode = 4'd2;
    for (int k = 0; k < 6; k++) begin
      push_instr(1'b0, 4'd2, 1'b0, 1, 1);
      drain(50);
    end

    // Reset during ALU_OP of STO: no write, PC select only, counts cleared
    opcode = 4'd6;
    push(1'b0, 10'b1000000000, {12'd0, ret_a});
    push(1'b0, 10'b1100000000, {12'd0, ret_a});
    push(1'b0, 10'b1110000000, {12'd0, ret_a});
    push(1'b0, 10'b1110000000, {12'd0, ret_a});
    push(1'b0, 10'b0000100000, {12'd0, ret_a});
    push(1'b0, 10'b0000000000, {12'd0, ret_a});
    push(1'b0, 10'b0000000010, {12'd0, ret_a});
    drain(50);
    rst_n = 1'b0;
    ret_a = 4'd0;
    ret_b = 16'd0;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, V_RST, 16'd0);
      push(1'b1, V_RST, 16'd0);
    end
    drain(50);

    // Wait states: memory not ready for the first five INST_FETCH cycles
    mem_ready = 1'b0;
    opcode = 4'd5;
    release_reset();
    push_instr(1'b1, 4'd5, 1'b0, 6, 3);
    push_instr(1'b0, 4'd5, 1'b0, 6, 1);
    drain(7);
    mem_ready = 1'b1;
    drain(50);
    // Ready memory: LDA takes 12 cycles on the MEM_WAIT=2 instance
    push_instr(1'b1, 4'd5, 1'b0, 3, 3);
    drain(50);

    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $error("FAIL drain: %0d/%0d expectations left unconsumed", qa.size(), qb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risc_ctrl_seq.md
Name: risc_ctrl_seq

Overview:
Parametrised successor to the CPU's 8-phase instruction-sequencing controller. It keeps the same phase flow and control strobes, and adds the following:
- configurable opcode width, with illegal-opcode detection;
- memory wait-state insertion (fixed minimum plus `mem_ready` handshake);
- a sticky HALTED state with a resume input;
- a retired-instruction counter.

It sits between instruction memory/IR decode, the ALU zero flag, and the PC/AC/IR/memory control strobes.

Parameters:
OPCODE_WIDTH, 3, width of opcode field (>=3); codes >7 are illegal.
MEM_WAIT, 0, minimum extra cycles each read phase holds before it may advance (0..15).
CNT_WIDTH, 16, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
opcode  in  OPCODE_WIDTH  IR opcode field.
is_zero  in  1  ALU accumulator-zero flag.
mem_ready  in  1  memory read data valid; tie 1 for zero-wait memory.
resume  in  1  single-cycle pulse; leaves HALTED.
sel  out  1  address mux: 1=PC, 0=IR operand.
rd  out  1  memory read enable.
ld_ir  out  1  load instruction register.
halt  out  1  CPU halted.
inc_pc  out  1  increment PC.
ld_ac  out  1  load accumulator.
ld_pc  out  1  load PC from operand.
wr  out  1  memory write strobe.
data_e  out  1  accumulator drives data bus.
illegal  out  1  one-cycle pulse: illegal opcode decoded.
retired  out  CNT_WIDTH  instructions completed, wraps.

Behaviour:
- Opcode encoding: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Decode flags: aluop = ADD|AND|XOR|LDA; ill = opcode>7. An illegal opcode drives no rd/ld_ac/ld_pc/wr/data_e/inc_pc beyond the normal OP_ADDR increment.
- States: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED. The state register is encoded internally.
- Outputs are decoded combinationally from the state and the decode flags. Any signal not listed for a state is 0.
  - INST_ADDR: sel=1. Next: INST_FETCH.
  - INST_FETCH: sel=1, rd=1. Holds until wait condition W is met, then goes to INST_LOAD.
  - INST_LOAD: sel=1, rd=1, ld_ir=1. Next: IDLE.
  - IDLE: sel=1, rd=1, ld_ir=1. Next: OP_ADDR.
  - OP_ADDR: inc_pc=1; illegal=ill. Next: HALTED if HLT, else OP_FETCH.
  - OP_FETCH: rd=aluop. If aluop, holds until W; otherwise advances next cycle. Next: ALU_OP.
  - ALU_OP: rd=aluop, inc_pc=SKZ&is_zero, ld_pc=JMP, data_e=STO. Next: STORE.
  - STORE: rd=aluop, ld_ac=aluop, ld_pc=JMP, wr=STO, data_e=STO. Next: INST_ADDR; retired increments by 1.
  - HALTED: halt=1, sel=1. Next: INST_ADDR when resume=1, else stays.
- Wait condition W:
  - A wait counter clears on entry to any read-hold state and increments each cycle, saturating at MEM_WAIT.
  - W = (cnt==MEM_WAIT) & mem_ready.
  - With MEM_WAIT=0 and mem_ready=1, timing is identical to the 8-phase baseline (8 cycles/instruction).
- HLT timing: halt rises on the cycle after OP_ADDR, not in OP_ADDR. HLT is not counted in retired. The PC has already incremented past HLT.
- resume behaviour: a resume pulse outside HALTED is ignored. Resume is sampled in HALTED only.
- Unknown/unreachable state encodings: all outputs 0, next state INST_ADDR.
- Reset (rst_n=0, asynchronous):
  - state=INST_ADDR, wait counter=0, retired=0.
  - Outputs forced: sel=1, all others 0, independent of state.
  - Reset mid-instruction abandons that instruction; no wr pulse may occur during reset.
- Counter wrap: retired wraps from all-ones to 0 without a flag.
- Simultaneous events:
  - mem_ready is ignored outside read-hold states.
  - is_zero is used only in ALU_OP.
  - opcode must be stable from IDLE through STORE.

Test Plan:
1. Reset release, MEM_WAIT=0, mem_ready=1, opcode=ADD → states cycle INST_ADDR..STORE in 8 clocks; rd=1 in cycles 2-4 and 6-8; ld_ac=1 in cycle 8 only; retired=1.
2. SKZ with is_zero=1, then with is_zero=0 → inc_pc=1 in OP_ADDR and ALU_OP (2 pulses) vs. OP_ADDR only (1 pulse); JMP → ld_pc=1 in ALU_OP and STORE.
3. STO → data_e=1 in ALU_OP and STORE; wr=1 only in STORE; rd=0 throughout the operand phase.
4. MEM_WAIT=2, mem_ready low for 5 cycles after entering INST_FETCH → INST_FETCH lasts 6 cycles; with mem_ready=1 always, it lasts exactly 3 cycles; an LDA instruction takes 12 cycles total.
5. HLT → halt=1 from the cycle after OP_ADDR; resume held 0 for 10 cycles keeps halt=1; resume pulse → INST_ADDR next cycle; retired unchanged.
6. OPCODE_WIDTH=4, opcode=9 → illegal=1 for one cycle in OP_ADDR, no rd/wr/ld_ac/ld_pc, retired+1. Separately, rst_n low during ALU_OP of STO → wr never asserts, sel=1, retired=0.
